// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, segment
// patterns, clamp limit and digit-enable codes.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    // Active-high segments, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int CLAMP_MAX = 99;

    localparam logic [1:0] DIG_UNITS = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

    // Double-dabble correction: add 3 to every BCD nibble that is >= 5
    function automatic logic [7:0] dd_adjust(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return r;
    endfunction

endpackage

// File: rtl/score_display_seg7_decoder.sv
// BCD nibble to 7-segment pattern; non-decimal nibbles are blank.
module seg7_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Binary score to two BCD digits via a one-step-per-cycle double-dabble,
// driving a time-multiplexed two-digit 7-segment display.
module score_display
    import score_display_pkg::*;
#(
    parameter int BW         = 7,
    parameter int REFRESH_BW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    digit_en_o,
    output logic [7:0]    bcd_o,
    output logic          busy_o
);

    localparam int IW = (BW > 1) ? $clog2(BW) : 1;

    state_e                state_q;
    logic [BW-1:0]         shifter_q;
    logic [7:0]            bcd_work_q;
    logic [IW-1:0]         iter_q;
    logic [BW-1:0]         cap_q;
    logic [BW-1:0]         last_q;
    logic [7:0]            bcd_q;
    logic                  busy_q;
    logic [REFRESH_BW-1:0] refresh_q;
    logic [1:0]            digit_en_q;

    logic [BW-1:0]         clamped_d;
    logic [7:0]            bcd_adj_d;
    logic [7:0]            bcd_work_d;
    logic [BW-1:0]         shifter_d;

    // Three BCD digits would be needed above 99, so larger inputs saturate
    always_comb begin
        clamped_d = value_i;
        if (32'(value_i) > CLAMP_MAX) clamped_d = BW'(CLAMP_MAX);
    end

    always_comb begin
        bcd_adj_d  = dd_adjust(bcd_work_q);
        bcd_work_d = {bcd_adj_d[6:0], shifter_q[BW-1]};
        shifter_d  = {shifter_q[BW-2:0], 1'b0};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            shifter_q  <= '0;
            bcd_work_q <= '0;
            iter_q     <= '0;
            cap_q      <= '0;
            last_q     <= '1;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (value_i != last_q) begin
                        cap_q      <= value_i;
                        shifter_q  <= clamped_d;
                        bcd_work_q <= '0;
                        iter_q     <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_work_q <= bcd_work_d;
                    shifter_q  <= shifter_d;
                    iter_q     <= iter_q + IW'(1);
                    if (iter_q == IW'(BW - 1)) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    // Remember the raw input so a held out-of-range value is not reconverted
                    bcd_q   <= bcd_work_q;
                    last_q  <= cap_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            refresh_q  <= '0;
            digit_en_q <= DIG_UNITS;
        end else begin
            refresh_q <= refresh_q + REFRESH_BW'(1);
            if (&refresh_q) digit_en_q <= {digit_en_q[0], digit_en_q[1]};
        end
    end

    logic       tens_sel;
    logic [3:0] nibble_sel;
    logic [6:0] dec_seg;

    assign tens_sel   = digit_en_q[1];
    assign nibble_sel = tens_sel ? bcd_q[7:4] : bcd_q[3:0];

    seg7_decoder u_dec (
        .nibble_i (nibble_sel),
        .seg_o    (dec_seg)
    );

    // Leading-zero blanking on the tens digit
    assign seg_o      = (tens_sel && bcd_q[7:4] == 4'd0) ? SEG_BLANK : dec_seg;
    assign digit_en_o = digit_en_q;
    assign bcd_o      = bcd_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: scoreboard of expected BCD results
// popped when busy_o falls, plus direct checks of latency, refresh and segments.
module tb_score_display;

    localparam int BW  = 7;
    localparam int RBW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [BW-1:0] value_i;
    logic [6:0]    seg_o;
    logic [1:0]    digit_en_o;
    logic [7:0]    bcd_o;
    logic          busy_o;

    score_display #(.BW(BW), .REFRESH_BW(RBW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .value_i    (value_i),
        .seg_o      (seg_o),
        .digit_en_o (digit_en_o),
        .bcd_o      (bcd_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd_of(input int v);
        int c;
        c = (v > 99) ? 99 : v;
        return {4'(c / 10), 4'(c % 10)};
    endfunction

    // Scoreboard monitor: a completed conversion is busy_o falling outside reset
    logic rst_seen  = 1'b1;
    logic busy_prev = 1'b0;
    always @(posedge clk) rst_seen <= rst_i;
    always @(negedge clk) begin
        if (!rst_seen && busy_prev === 1'b1 && busy_o === 1'b0) begin
            chk("sb_depth", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) chk("sb_bcd", 32'(bcd_o), 32'(sb_q.pop_front()));
        end
        busy_prev <= busy_o;
    end

    task automatic drive(input logic [BW-1:0] v);
        @(posedge clk);
        #1;
        value_i = v;
        sb_q.push_back(bcd_of(int'(v)));
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && busy_o == 1'b0) break;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic check_seg(input logic [6:0] tens_exp, input logic [6:0] units_exp);
        logic got_t, got_u;
        got_t = 1'b0;
        got_u = 1'b0;
        for (int i = 0; i < 20 && !(got_t && got_u); i++) begin
            @(negedge clk);
            if (digit_en_o == 2'b10 && !got_t) begin
                chk("seg_tens", 32'(seg_o), 32'(tens_exp));
                got_t = 1'b1;
            end else if (digit_en_o == 2'b01 && !got_u) begin
                chk("seg_units", 32'(seg_o), 32'(units_exp));
                got_u = 1'b1;
            end
        end
        chk("seg_seen", 32'({got_t, got_u}), 32'd3);
    endtask

    initial begin
        logic [19:0] busy_got, busy_exp;
        int          busy_cnt;

        // Reset with value 0: one conversion follows because last_q resets to 127
        rst_i   = 1'b1;
        value_i = '0;
        sb_q.push_back(bcd_of(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_bcd",   32'(bcd_o),      32'h00);
        chk("rst_den",   32'(digit_en_o), 32'h1);
        chk("rst_seg",   32'(seg_o),      32'h3F);
        chk("rst_busy",  32'(busy_o),     32'h0);
        rst_i = 1'b0;

        // Refresh: digit enable toggles every 4 cycles from reset release
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("refresh_%0d", k), 32'(digit_en_o), ((k / 4) % 2) ? 32'h2 : 32'h1);
            if (k == 1) chk("first_conv_busy", 32'(busy_o), 32'h1);
        end
        drain();

        // Single conversion: latency and busy width
        drive(7'd42);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (i == 7) chk("lat_pre", 32'(bcd_o), 32'h00);
            if (i == 8) chk("lat_42",  32'(bcd_o), 32'h42);
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd8);
        drain();
        check_seg(7'h66, 7'h5B);

        // Boundaries and clamp
        drive(7'd99);  drain();
        drive(7'd100); drain();
        drive(7'd127); drain();
        chk("clamp_127", 32'(bcd_o), 32'h99);
        drive(7'd9);   drain();
        check_seg(7'h00, 7'h6F);

        // Change mid-conversion: 42 completes, one idle cycle, then 17
        drive(7'd42);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                value_i = 7'd17;
                sb_q.push_back(bcd_of(17));
            end
            @(negedge clk);
            busy_got[i] = busy_o;
            busy_exp[i] = (i <= 7) || (i >= 9 && i <= 16);
        end
        chk("busy_seq", 32'(busy_got), 32'(busy_exp));
        drain();
        chk("mid_final", 32'(bcd_o), 32'h17);

        // Reset during CONV: aborted result stays queued for the reconversion
        drive(7'd55);
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rmid_busy", 32'(busy_o), 32'h0);
        chk("rmid_bcd",  32'(bcd_o),  32'h00);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rmid_reconv", 32'(busy_o), 32'h1);
        drain();
        chk("rmid_final", 32'(bcd_o), 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
